// File: rtl/nco_step_meas.sv
// nco_step_meas
//
// Measures the frequency of an asynchronous 1-bit waveform and reports it as
// the NCO step word that reproduces it: f = step * f_clk / 2^WIDTH.
// Rising edges of the synchronized input are counted over a gate of
// 2^GATE_LOG2 clocks. The step word is the edge count shifted left by
// (WIDTH - GATE_LOG2).
//
// Ports:
//   clk         system clock; all state updates on its rising edge
//   reset       asynchronous, active-high reset
//   sig_in      asynchronous waveform under measurement
//   start       request a measurement (honoured only in IDLE)
//   abort       synchronous cancel, returns to IDLE from any state
//   busy        high while arming or measuring
//   meas_valid  result available (DONE)
//   meas_ready  consumer accepts the result
//   edge_count  rising edges counted in the last completed gate
//   step_out    edge_count << (WIDTH - GATE_LOG2), zero-extended
//
// Parameter constraints: WIDTH > GATE_LOG2, GATE_LOG2 >= 2, SYNC_STAGES >= 2.
module nco_step_meas #(
  parameter int WIDTH       = 32,
  parameter int GATE_LOG2   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic [GATE_LOG2:0]   edge_count,
  output logic [WIDTH-1:0]     step_out
);

  localparam int ARM_W = $clog2(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t                   state_reg, state_next;
  logic [SYNC_STAGES-1:0]   sync_reg;
  logic                     prev_reg;
  logic [ARM_W-1:0]         arm_cnt_reg;
  logic [GATE_LOG2-1:0]     gate_cnt_reg;
  logic [GATE_LOG2:0]       acc_reg;
  logic [GATE_LOG2:0]       edge_count_reg;
  logic [WIDTH-1:0]         step_out_reg;

  logic                     rise;
  logic                     arm_last;
  logic                     gate_last;
  logic                     load_result;
  logic [GATE_LOG2:0]       acc_total;

  assign rise      = sync_reg[SYNC_STAGES-1] & ~prev_reg;
  assign arm_last  = (arm_cnt_reg == ARM_W'(SYNC_STAGES - 1));
  assign gate_last = &gate_cnt_reg;
  // The final gate cycle's edge is folded in while the result is captured.
  assign acc_total = acc_reg + {{GATE_LOG2{1'b0}}, rise};
  // Abort on the last gate cycle discards the measurement.
  assign load_result = (state_reg == MEASURE) && gate_last && !abort;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort has priority over every other request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) state_next = ARM;
      end
      ARM: begin
        if (abort)         state_next = IDLE;
        else if (arm_last) state_next = MEASURE;
      end
      MEASURE: begin
        if (abort)          state_next = IDLE;
        else if (gate_last) state_next = DONE;
      end
      DONE: begin
        if (abort || meas_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Synchronizer, edge-detect history, counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg       <= '0;
      prev_reg       <= 1'b0;
      arm_cnt_reg    <= '0;
      gate_cnt_reg   <= '0;
      acc_reg        <= '0;
      edge_count_reg <= '0;
      step_out_reg   <= '0;
    end else begin
      // The synchronizer runs in every state so ARM only has to wait out
      // its depth before edges are trusted.
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];

      case (state_reg)
        ARM: begin
          arm_cnt_reg  <= arm_cnt_reg + ARM_W'(1);
          gate_cnt_reg <= '0;
          acc_reg      <= '0;
        end
        MEASURE: begin
          arm_cnt_reg  <= '0;
          gate_cnt_reg <= gate_cnt_reg + GATE_LOG2'(1);
          acc_reg      <= acc_total;
        end
        default: begin
          arm_cnt_reg  <= '0;
          gate_cnt_reg <= '0;
          acc_reg      <= '0;
        end
      endcase

      if (abort) begin
        arm_cnt_reg  <= '0;
        gate_cnt_reg <= '0;
        acc_reg      <= '0;
      end

      // Max count is 2^(GATE_LOG2-1), so the shifted value fits in WIDTH bits.
      if (load_result) begin
        edge_count_reg <= acc_total;
        step_out_reg   <= WIDTH'(acc_total) << (WIDTH - GATE_LOG2);
      end
    end
  end

  assign busy       = (state_reg == ARM) || (state_reg == MEASURE);
  assign meas_valid = (state_reg == DONE);
  assign edge_count = edge_count_reg;
  assign step_out   = step_out_reg;

endmodule

// File: tb/tb_nco_step_meas.sv
module tb_nco_step_meas;

  localparam int WIDTH       = 32;
  localparam int GATE_LOG2   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LATENCY     = SYNC_STAGES + (1 << GATE_LOG2);  // 258

  logic                 clk;
  logic                 reset;
  logic                 sig_in;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 meas_valid;
  logic                 meas_ready;
  logic [GATE_LOG2:0]   edge_count;
  logic [WIDTH-1:0]     step_out;

  nco_step_meas #(
    .WIDTH      (WIDTH),
    .GATE_LOG2  (GATE_LOG2),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .edge_count(edge_count),
    .step_out  (step_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waveform source: period 0 means hold wave_hold constant.
  int   wave_period = 0;
  logic wave_hold   = 1'b0;
  int   wave_phase  = 0;

  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (wave_period == 0) begin
        sig_in = wave_hold;
      end else begin
        wave_phase = (wave_phase + 1) % wave_period;
        sig_in     = (wave_phase < wave_period / 2);
      end
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Select a waveform, let it settle, then pulse start (sampled at "edge 0").
  task automatic start_run(input int period, input logic hold);
    wave_period = period;
    wave_hold   = hold;
    wave_phase  = 0;
    repeat (6) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges after edge 0 until meas_valid is seen (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (!meas_valid && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic ack();
    meas_ready = 1'b1;
    tick();
    meas_ready = 1'b0;
  endtask

  typedef struct {
    int               period;
    logic             hold;
    logic [GATE_LOG2:0] exp_cnt;
    logic [WIDTH-1:0] exp_step;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;

    vecs[0] = '{8, 1'b0, 9'd32,  32'h2000_0000};
    vecs[1] = '{2, 1'b0, 9'd128, 32'h8000_0000};
    vecs[2] = '{0, 1'b1, 9'd0,   32'h0000_0000};
    vecs[3] = '{0, 1'b0, 9'd0,   32'h0000_0000};
    vecs[4] = '{4, 1'b0, 9'd64,  32'h4000_0000};

    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    meas_ready = 1'b0;
    repeat (3) tick();
    check("reset_busy",       busy,       0);
    check("reset_valid",      meas_valid, 0);
    check("reset_edge_count", edge_count, 0);
    check("reset_step_out",   step_out,   0);
    reset = 1'b0;
    tick();

    // Table-driven measurement runs with immediate acceptance.
    for (int i = 0; i < 5; i++) begin
      start_run(vecs[i].period, vecs[i].hold);
      check($sformatf("v%0d_busy_after_start", i), busy, 1);
      wait_valid(n);
      check($sformatf("v%0d_latency", i), n, LATENCY);
      check($sformatf("v%0d_edge_count", i), edge_count, vecs[i].exp_cnt);
      check($sformatf("v%0d_step_out", i), step_out, vecs[i].exp_step);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
      ack();
      check($sformatf("v%0d_valid_after_ack", i), meas_valid, 0);
    end

    // Back-pressure: hold ready low for 10 cycles, stray start during DONE.
    start_run(8, 1'b0);
    wait_valid(n);
    check("hold_latency", n, LATENCY);
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      tick();
      check($sformatf("hold_c%0d_valid", c), meas_valid, 1);
      check($sformatf("hold_c%0d_edge_count", c), edge_count, 32);
      check($sformatf("hold_c%0d_step_out", c), step_out, 32'h2000_0000);
    end
    start = 1'b0;
    ack();
    check("hold_valid_after_ack", meas_valid, 0);
    check("hold_busy_after_ack", busy, 0);
    tick();
    check("hold_stray_start_ignored", busy, 0);

    // Abort in MEASURE keeps the previous result and produces no valid.
    start_run(8, 1'b0);
    repeat (102) tick();
    check("abort_busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", meas_valid, 0);
    check("abort_edge_count_kept", edge_count, 32);
    seen = 1'b0;
    repeat (300) begin
      tick();
      if (meas_valid) seen = 1'b1;
    end
    check("abort_no_valid_later", seen, 0);
    start_run(4, 1'b0);
    wait_valid(n);
    check("post_abort_latency", n, LATENCY);
    check("post_abort_edge_count", edge_count, 64);
    check("post_abort_step_out", step_out, 32'h4000_0000);
    ack();

    // Abort in DONE (together with start), then abort+start in IDLE.
    start_run(2, 1'b0);
    wait_valid(n);
    check("done_abort_latency", n, LATENCY);
    abort = 1'b1;
    start = 1'b1;
    tick();
    check("done_abort_valid", meas_valid, 0);
    check("done_abort_busy", busy, 0);
    tick();
    check("idle_abort_beats_start", busy, 0);
    abort = 1'b0;
    start = 1'b0;
    check("done_abort_edge_count_kept", edge_count, 128);

    // Asynchronous reset mid-MEASURE, between clock edges.
    start_run(8, 1'b0);
    repeat (50) tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_busy",       busy,       0);
    check("areset_valid",      meas_valid, 0);
    check("areset_edge_count", edge_count, 0);
    check("areset_step_out",   step_out,   0);
    #1;
    reset = 1'b0;
    start_run(8, 1'b0);
    wait_valid(n);
    check("post_reset_latency", n, LATENCY);
    check("post_reset_edge_count", edge_count, 32);
    check("post_reset_step_out", step_out, 32'h2000_0000);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_step_meas.md
Name: nco_step_meas

Overview:
- Measures the frequency of an external 1-bit waveform and reports it as an NCO step word, where f = step * f_clk / 2^WIDTH.
- A sampled carrier or code reference is converted into the step value that makes the nco block reproduce it.
- Used for acquisition seeding and loop sanity checks, on the same clock as the NCO.
- Counts synchronized rising edges over a fixed gate of 2^GATE_LOG2 clocks and returns the result on a valid/ready handshake.

Parameters:
- WIDTH, 32, step word width; must equal the nco WIDTH; requires WIDTH > GATE_LOG2.
- GATE_LOG2, 16, gate length is 2^GATE_LOG2 clock cycles; range 2..WIDTH-1.
- SYNC_STAGES, 2, flip-flop stages synchronizing sig_in; minimum 2.

Ports:
- clk  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous 1-bit waveform under measurement.
- start  input  1  request a measurement; honoured only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- busy  output  1  high in ARM and MEASURE.
- meas_valid  output  1  result available (DONE state).
- meas_ready  input  1  consumer accepts the result.
- edge_count  output  GATE_LOG2+1  rising edges counted in the last gate.
- step_out  output  WIDTH  edge_count << (WIDTH-GATE_LOG2), zero-extended.

Behaviour:
- Reset (asynchronous assert, released on a clk edge):
  - state=IDLE; synchronizer, previous-sample and counters cleared.
  - busy=0, meas_valid=0, edge_count=0, step_out=0.
- Synchronizer and edge detect:
  - sig_in passes through SYNC_STAGES flops, plus one prev register, every cycle in every state.
  - rise = sync & ~prev.
- FSM states: IDLE, ARM, MEASURE, DONE.
  - IDLE: start=1 and abort=0 -> ARM; arm counter=0.
  - ARM: lasts exactly SYNC_STAGES cycles to flush stale synchronizer history. No edges are counted. Then -> MEASURE; gate counter=0, edge accumulator=0.
  - MEASURE: lasts exactly 2^GATE_LOG2 cycles. The accumulator increments on each cycle with rise=1. After the last gate cycle -> DONE. On that same edge, edge_count and step_out load, and the final cycle's rise is included.
  - DONE: meas_valid=1; edge_count and step_out are held stable. meas_valid & meas_ready -> IDLE, with meas_valid low the next cycle. A new start is accepted one cycle later, from IDLE.
- Latency: if start is sampled at edge 0, meas_valid rises at edge SYNC_STAGES + 2^GATE_LOG2.
- Arithmetic:
  - Maximum edges per gate is 2^(GATE_LOG2-1), because a rise needs at least 2 cycles. The GATE_LOG2+1 bit accumulator cannot overflow.
  - The step_out shift never exceeds 2^(WIDTH-1), so no saturation is needed.
- Outputs edge_count and step_out change only on entry to DONE. They keep the last result through IDLE, ARM and MEASURE.
- Boundary conditions:
  - start while busy or in DONE: ignored, no queueing.
  - abort in ARM or MEASURE: -> IDLE; counters cleared; outputs keep the previous result.
  - abort in DONE: -> IDLE, meas_valid drops, and the result is not consumed.
  - abort and start in the same cycle: abort wins.
  - abort and meas_ready in the same cycle in DONE: -> IDLE, same effect as either alone.
  - meas_ready asserted outside DONE: no effect.
  - Constant sig_in: edge_count=0, step_out=0.
  - Reset asserted mid-ARM, mid-MEASURE or in DONE: immediate return to reset values, no clock required.

Test Plan (GATE_LOG2=8, SYNC_STAGES=2, WIDTH=32 unless noted):
- Square wave, period 8 clk, start pulsed -> meas_valid exactly 258 edges after start; edge_count=32; step_out=0x20000000.
- Toggle every clk (period 2) -> edge_count=128, step_out=0x80000000.
- sig_in held 1, then held 0 -> edge_count=0, step_out=0 each run.
- Period-8 run with meas_ready low for 10 cycles after valid and start pulsed during the hold -> outputs stable, meas_valid held. Accepted on the ready cycle, then IDLE; the extra start is ignored.
- abort at MEASURE cycle 100 after a prior result of 32 -> busy drops next cycle, no meas_valid, edge_count stays 32. A fresh start with a period-4 wave gives 64, 0x40000000.
- Asynchronous reset pulse mid-MEASURE, between clk edges -> busy, meas_valid, edge_count, step_out read 0 before the next clk edge; the next run measures normally.
